seq_alu: RTL and testbench

//  Parametrised sequential ALU: WIDTH-bit operands, 12 ops incl. shifts, signed compare and
//  a multi-cycle shift-add multiply. Valid/ready handshake on both sides, registered result,
//  Z/N/C/V/err flags, and a hex 7-segment view of the last result for the board display.

---
 rtl/seq_alu.sv | 225 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential WIDTH-bit ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish one cycle after accept. MUL is a shift-add multiply
// that takes WIDTH cycles, paced by a down-counter.
// The result, the flags and a hex 7-segment view are registered on entry to DONE.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | in_ready=1, waiting for an operation
// MUL    | shift-add multiply running, one partial product per cycle
// DONE   | out_valid=1, result held until the consumer takes it
module seq_alu #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = (WIDTH + 3) / 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [3:0]            op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic [4:0]            flags,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                   accept;
    logic [SH_W-1:0]        sh;
    logic [WIDTH:0]         add_full;
    logic [WIDTH:0]         sub_full;
    logic signed [WIDTH-1:0] a_s;

    logic [WIDTH-1:0]       alu_res;
    logic                   alu_c;
    logic                   alu_v;
    logic                   alu_err;

    logic [2*WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]       mplier;
    logic [2*WIDTH-1:0]     acc;
    logic [SH_W-1:0]        mul_cnt;
    logic [2*WIDTH-1:0]     prod_step;
    logic                   mul_last;

    logic                   wr_done;
    logic [WIDTH-1:0]       res_d;
    logic [4:0]             flags_d;
    logic [4*DIGITS-1:0]    res_pad;
    logic [7*DIGITS-1:0]    seg_d;

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign accept    = in_valid & in_ready;
    assign sh        = b[SH_W-1:0];
    assign add_full  = {1'b0, a} + {1'b0, b};
    assign sub_full  = {1'b0, a} - {1'b0, b};
    assign a_s       = a;
    assign prod_step = acc + (mplier[0] ? mcand : '0);
    assign mul_last  = (mul_cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (op == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Single-cycle operations and their carry/overflow/err contributions.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: alu_res = ~a;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLT: alu_res = WIDTH'($signed(a) < $signed(b));
            OP_EQ:  alu_res = WIDTH'(a == b);
            OP_SLL: alu_res = a << sh;
            OP_SRL: alu_res = a >> sh;
            OP_SRA: alu_res = a_s >>> sh;
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Select what is written on entry to DONE and build its 7-seg image.
    always_comb begin
        wr_done = (accept && (op != OP_MUL)) || ((state == S_MUL) && mul_last);
        if (state == S_MUL) begin
            res_d   = prod_step[WIDTH-1:0];
            flags_d = {1'b0, 1'b0, |prod_step[2*WIDTH-1:WIDTH],
                       prod_step[WIDTH-1], (prod_step[WIDTH-1:0] == '0)};
        end else begin
            res_d   = alu_res;
            flags_d = {alu_err, alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
        end
        res_pad = (4*DIGITS)'(res_d);
        seg_d   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            seg_d[7*i +: 7] = hex7(res_pad[4*i +: 4]);
        end
    end

    // Output registers plus the multiplier datapath and its iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            flags   <= '0;
            seg     <= '1;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            mul_cnt <= '0;
        end else begin
            if (wr_done) begin
                result <= res_d;
                flags  <= flags_d;
                seg    <= seg_d;
            end
            if (accept && (op == OP_MUL)) begin
                acc     <= '0;
                mcand   <= {{WIDTH{1'b0}}, a};
                mplier  <= b;
                mul_cnt <= SH_W'(WIDTH - 1);
            end else if (state == S_MUL) begin
                acc     <= prod_step;
                mcand   <= {mcand[2*WIDTH-2:0], 1'b0};
                mplier  <= {1'b0, mplier[WIDTH-1:1]};
                mul_cnt <= mul_cnt - SH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random operations against an arithmetic reference model.
module tb_seq_alu;

    localparam int W   = 8;
    localparam int DIG = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [4:0]       flags;
    logic [7*DIG-1:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions.
    task automatic ref_model(input int opv, input int av, input int bv,
                             output int r, output logic [4:0] fl);
        int sa, sb, s, sh;
        logic c, v, e;
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        sh = bv % 8;
        c = 1'b0; v = 1'b0; e = 1'b0; r = 0;
        case (opv)
            0:  begin s = av + bv; r = s % 256; c = (s > 255);
                      v = (sa + sb > 127) || (sa + sb < -128); end
            1:  begin s = av - bv; r = (s + 256) % 256; c = (av < bv);
                      v = (sa - sb > 127) || (sa - sb < -128); end
            2:  r = 255 - av;
            3:  r = av & bv;
            4:  r = av | bv;
            5:  r = av ^ bv;
            6:  r = (sa < sb) ? 1 : 0;
            7:  r = (av == bv) ? 1 : 0;
            8:  r = (av << sh) % 256;
            9:  r = av >> sh;
            10: r = (sa >>> sh) & 255;
            11: begin s = av * bv; r = s % 256; c = (s > 255); end
            default: e = 1'b1;
        endcase
        fl = {e, v, c, (r >= 128), (r == 0)};
    endtask

    task automatic run_op(input int opv, input int av, input int bv, input int stall);
        int          er;
        int          lat;
        logic [4:0]  ef;
        logic [13:0] eseg;
        ref_model(opv, av, bv, er, ef);
        eseg = {glyph[er / 16], glyph[er % 16]};
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        op        = opv[3:0];
        a         = av[7:0];
        b         = bv[7:0];
        out_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 3 * W) begin
            in_valid = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (opv == 11) ? W + 1 : 1);
        chk("result", result, er);
        chk("flags", flags, ef);
        chk("seg", seg, eseg);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 4'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", result, er);
            chk("hold_flags", flags, ef);
            chk("hold_seg", seg, eseg);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("xfer_out_valid", out_valid, 0);
        chk("xfer_in_ready", in_ready, 1);
        chk("xfer_seg_hold", seg, eseg);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a  = '0;
        b  = '0;
        op = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_seg", seg, 14'h3FFF);

        run_op(0, 'h7F, 'h01, 0);
        chk("add_result", result, 'h80);
        chk("add_flags", flags, 5'b01010);
        chk("add_seg", seg, 14'b0000000_1000000);
        run_op(1, 'h00, 'h01, 0);
        chk("sub_result", result, 'hFF);
        chk("sub_flags", flags, 5'b00110);
        run_op(7, 'h5A, 'h5A, 1);
        chk("eq_result", result, 'h01);
        run_op(11, 'h0F, 'h11, 0);
        chk("mul_result", result, 'hFF);
        chk("mul_c", flags[2], 0);
        run_op(11, 'h10, 'h10, 0);
        chk("mul0_result", result, 'h00);
        chk("mul0_zc", {flags[2], flags[0]}, 2'b11);
        run_op(10, 'h80, 3, 0);
        chk("sra_result", result, 'hF0);
        run_op(6, 'hFF, 'h01, 0);
        chk("slt_result", result, 'h01);
        run_op(15, 'h33, 'h44, 0);
        chk("ill_result", result, 0);
        chk("ill_err", flags[4], 1);
        run_op(4, 'hA5, 'h18, 5);

        // Reset during the third MUL cycle aborts with no output.
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'd11;
        a  = 8'h37;
        b  = 8'h5B;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mul_busy", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_seg", seg, 14'h3FFF);
        chk("abort_result", result, 0);
        repeat (12) @(negedge clk);
        chk("abort_no_output", out_valid, 0);

        for (int i = 0; i < 200; i++) begin
            int rop;
            rop = ($urandom_range(0, 4) == 0) ? 11 : int'($urandom_range(0, 15));
            run_op(rop, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
